// File: rtl/hex_rotation_decoder.sv
// rtl/hex_rotation_decoder.sv - recovers the A/G/P/F rotation code from four debounced HEX buses
// Optional FAULT entry counter on ERR_CNT is built when HEX_ROT_DEC_ERRCNT_EN is defined.
module hex_rotation_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       RESETN,
  input  logic [0:6] HEX0,
  input  logic [0:6] HEX1,
  input  logic [0:6] HEX2,
  input  logic [0:6] HEX3,
  output logic [1:0] ROT,
  output logic       BLANK,
  output logic       LOCKED,
  output logic       VALID,
  output logic       ERR,
  output logic [7:0] ERR_CNT
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);

  // Returns {is_letter, letter_index}; argument bit 6 is segment a.
  function automatic logic [2:0] letter_decode(input logic [6:0] p);
    case (p)
      7'b0001000: letter_decode = 3'b100;
      7'b0100001: letter_decode = 3'b101;
      7'b0011000: letter_decode = 3'b110;
      7'b0111000: letter_decode = 3'b111;
      default:    letter_decode = 3'b000;
    endcase
  endfunction

  logic [27:0] hex_in;
  logic [27:0] s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  state_q, state_d;
  logic [1:0]  rot_q, rot_d;
  logic        blank_q, blank_d;
  logic        locked_q, locked_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic [2:0]  dec0, dec1, dec2, dec3;
  logic [1:0]  r0, r1, r2, r3;
  logic        changed, decide, consistent, all_blank;

  assign hex_in = {HEX3, HEX2, HEX1, HEX0};

  // Classification works on the registered sample only, so no HEX-to-output path exists.
  assign dec0 = letter_decode(s_q[6:0]);
  assign dec1 = letter_decode(s_q[13:7]);
  assign dec2 = letter_decode(s_q[20:14]);
  assign dec3 = letter_decode(s_q[27:21]);

  assign r0 = 2'd0 - dec0[1:0];
  assign r1 = 2'd1 - dec1[1:0];
  assign r2 = 2'd2 - dec2[1:0];
  assign r3 = 2'd3 - dec3[1:0];

  assign consistent = dec0[2] && dec1[2] && dec2[2] && dec3[2] &&
                      (r0 == r1) && (r0 == r2) && (r0 == r3);
  assign all_blank  = (s_q == 28'hFFF_FFFF);

  assign changed = (hex_in != s_q);
  // A frame change landing on the deciding edge suppresses the decision.
  assign decide  = !changed && (cnt_q == STABLE_MAX - 16'd1);

  always_comb begin
    cnt_d    = changed ? 16'd0 : ((cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 16'd1);
    state_d  = state_q;
    rot_d    = rot_q;
    blank_d  = blank_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SETTLE;
        cnt_d   = 16'd0;
      end
      ST_SETTLE: begin
        if (decide) begin
          if (consistent) begin
            state_d  = ST_LOCKED;
            rot_d    = r0;
            blank_d  = 1'b0;
            locked_d = 1'b1;
            valid_d  = 1'b1;
          end else if (all_blank) begin
            state_d  = ST_LOCKED;
            blank_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            state_d  = ST_FAULT;
            err_d    = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (changed) begin
          state_d  = ST_SETTLE;
          locked_d = 1'b0;
          blank_d  = 1'b0;
        end
      end
      default: begin
        if (changed) begin
          state_d = ST_SETTLE;
          err_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      s_q      <= 28'hFFF_FFFF;
      cnt_q    <= 16'd0;
      state_q  <= ST_IDLE;
      rot_q    <= 2'd0;
      blank_q  <= 1'b0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      s_q      <= hex_in;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      rot_q    <= rot_d;
      blank_q  <= blank_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

`ifdef HEX_ROT_DEC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLOCK_50) begin
    if (!RESETN) begin
      err_cnt_q <= 8'd0;
    end else if (state_q == ST_SETTLE && state_d == ST_FAULT && err_cnt_q != 8'd255) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'd0;
`endif

  assign ROT    = rot_q;
  assign BLANK  = blank_q;
  assign LOCKED = locked_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_hex_rotation_decoder.sv
// tb/tb_hex_rotation_decoder.sv - directed self-checking bench for hex_rotation_decoder
module tb_hex_rotation_decoder;

  localparam logic [6:0] L_A = 7'b0001000;
  localparam logic [6:0] L_G = 7'b0100001;
  localparam logic [6:0] L_P = 7'b0011000;
  localparam logic [6:0] L_F = 7'b0111000;
  localparam logic [6:0] L_B = 7'b1111111;

  logic       CLOCK_50;
  logic       RESETN;
  logic [0:6] HEX0, HEX1, HEX2, HEX3;
  logic [1:0] ROT;
  logic       BLANK, LOCKED, VALID, ERR;
  logic [7:0] ERR_CNT;

  int n_checks = 0;
  int n_errors = 0;
  int faults   = 0;

  hex_rotation_decoder #(.STABLE_CYCLES(16)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESETN   (RESETN),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .ROT      (ROT),
    .BLANK    (BLANK),
    .LOCKED   (LOCKED),
    .VALID    (VALID),
    .ERR      (ERR),
    .ERR_CNT  (ERR_CNT)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef HEX_ROT_DEC_ERRCNT_EN
    exp_cnt = (n > 255) ? 8'd255 : 8'(n);
`else
    exp_cnt = 8'd0;
`endif
  endfunction

  // Called and returns just after a falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic set_frame(input logic [6:0] h0, input logic [6:0] h1,
                           input logic [6:0] h2, input logic [6:0] h3);
    HEX0 = h0;
    HEX1 = h1;
    HEX2 = h2;
    HEX3 = h3;
  endtask

  // Applies a new frame and checks the full 16-edge settle and the decision that follows.
  task automatic expect_decide(input logic [6:0] h0, input logic [6:0] h1,
                               input logic [6:0] h2, input logic [6:0] h3,
                               input logic e_locked, input logic e_valid, input logic [1:0] e_rot,
                               input logic e_blank, input logic e_err, input logic [7:0] e_cnt);
    set_frame(h0, h1, h2, h3);
    tick(1);
    chk("cap_locked", LOCKED, 0);
    chk("cap_err", ERR, 0);
    chk("cap_valid", VALID, 0);
    tick(15);
    chk("pre_locked", LOCKED, 0);
    chk("pre_valid", VALID, 0);
    chk("pre_err", ERR, 0);
    tick(1);
    chk("dec_locked", LOCKED, e_locked);
    chk("dec_valid", VALID, e_valid);
    chk("dec_rot", ROT, e_rot);
    chk("dec_blank", BLANK, e_blank);
    chk("dec_err", ERR, e_err);
    chk("dec_errcnt", ERR_CNT, e_cnt);
    chk("valid_with_err", VALID & ERR, 0);
    tick(1);
    chk("post_valid", VALID, 0);
    chk("post_locked", LOCKED, e_locked);
  endtask

  initial begin
    RESETN = 1'b0;
    set_frame(L_B, L_B, L_B, L_B);
    @(negedge CLOCK_50);
    tick(2);
    chk("rst_rot", ROT, 0);
    chk("rst_blank", BLANK, 0);
    chk("rst_locked", LOCKED, 0);
    chk("rst_valid", VALID, 0);
    chk("rst_err", ERR, 0);
    chk("rst_errcnt", ERR_CNT, 0);

    RESETN = 1'b1;
    expect_decide(L_A, L_G, L_P, L_F, 1, 1, 2'd0, 0, 0, exp_cnt(0));
    expect_decide(L_P, L_F, L_A, L_G, 1, 1, 2'd2, 0, 0, exp_cnt(0));
    expect_decide(L_G, L_P, L_F, L_A, 1, 1, 2'd3, 0, 0, exp_cnt(0));
    expect_decide(L_B, L_B, L_B, L_B, 1, 0, 2'd3, 1, 0, exp_cnt(0));

    // One-cycle glitch on HEX2 restarts the count from the restored frame.
    set_frame(L_F, L_A, L_G, L_P);
    tick(10);
    chk("glitch_hold_locked", LOCKED, 0);
    set_frame(L_F, L_A, L_A, L_P);
    tick(1);
    chk("glitch_locked", LOCKED, 0);
    expect_decide(L_F, L_A, L_G, L_P, 1, 1, 2'd1, 0, 0, exp_cnt(0));

    // A change captured on the would-be deciding edge must win.
    set_frame(L_A, L_G, L_P, L_F);
    tick(16);
    chk("edge_race_locked", LOCKED, 0);
    expect_decide(L_P, L_F, L_A, L_G, 1, 1, 2'd2, 0, 0, exp_cnt(0));

    faults = 1;
    expect_decide(L_A, L_A, L_P, L_F, 0, 0, 2'd2, 0, 1, exp_cnt(faults));
    for (int i = 0; i < 300; i++) begin
      expect_decide(L_B, L_B, L_B, L_B, 1, 0, 2'd2, 1, 0, exp_cnt(faults));
      faults++;
      expect_decide(L_A, L_A, L_P, L_F, 0, 0, 2'd2, 0, 1, exp_cnt(faults));
    end
    chk("sat_errcnt", ERR_CNT, exp_cnt(301));

    // Reset at count 12 of a SETTLE that follows a FAULT.
    set_frame(L_B, L_B, L_B, L_B);
    tick(13);
    chk("mid_locked", LOCKED, 0);
    RESETN = 1'b0;
    tick(1);
    chk("rst2_rot", ROT, 0);
    chk("rst2_blank", BLANK, 0);
    chk("rst2_locked", LOCKED, 0);
    chk("rst2_valid", VALID, 0);
    chk("rst2_err", ERR, 0);
    chk("rst2_errcnt", ERR_CNT, 0);
    RESETN = 1'b1;
    expect_decide(L_A, L_A, L_P, L_F, 0, 0, 2'd0, 0, 1, exp_cnt(1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
